// File: rtl/ysyx_22040088_mem_pkg.sv
// Shared types and helpers for the NPC memory arbiter.
// Optional WAIT timeout: define MEMARB_TIMEOUT_EN.
package ysyx_22040088_mem_pkg;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RESP, ERR, DRAIN
  } state_t;

  typedef enum logic {
    OWN_IF, OWN_LS
  } owner_t;

  localparam logic [3:0] MASK_D = 4'b0001;
  localparam logic [3:0] MASK_W = 4'b0010;
  localparam logic [3:0] MASK_H = 4'b0100;
  localparam logic [3:0] MASK_B = 4'b1000;

  function automatic logic [7:0] size_to_strb(
    input logic [3:0] mask
  );
    logic [7:0] s;
    unique case (mask)
      MASK_D:  s = 8'hFF;
      MASK_W:  s = 8'h0F;
      MASK_H:  s = 8'h03;
      MASK_B:  s = 8'h01;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // An illegal (non one-hot) mask counts as misaligned.
  function automatic logic misaligned(
    input logic [3:0] mask,
    input logic [2:0] off
  );
    logic m;
    unique case (mask)
      MASK_D:  m = |off;
      MASK_W:  m = |off[1:0];
      MASK_H:  m = off[0];
      MASK_B:  m = 1'b0;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040088_mem_lane_align.sv
// Byte-lane steering: store strobes/data out, load data back in.
// Optional WAIT timeout in the top: define MEMARB_TIMEOUT_EN.
module ysyx_22040088_mem_lane_align
  import ysyx_22040088_mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]        w_mask,
  input  logic [2:0]        w_off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        r_mask,
  input  logic [2:0]        r_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [7:0]        wstrb,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] shifted;

  // Store side: strobes and data moved up to the addressed lane.
  always_comb begin
    wstrb    = size_to_strb(w_mask) << w_off;
    wdata_sh = wdata << {w_off, 3'b000};
  end

  // Load side: move lane down, keep only the access size.
  always_comb begin
    shifted = rdata >> {r_off, 3'b000};
    unique case (r_mask)
      MASK_D:  rdata_ext = shifted;
      MASK_W:  rdata_ext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
      MASK_H:  rdata_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      MASK_B:  rdata_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040088_mem_arbiter.sv
// IF/LS arbiter onto one memory port, one transaction in flight.
// Optional WAIT timeout with DRAIN recovery: define MEMARB_TIMEOUT_EN.
module ysyx_22040088_mem_arbiter
  import ysyx_22040088_mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
`ifdef MEMARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  output logic              if_resp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wen,
  input  logic [3:0]        ls_mask,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              ls_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  state_t     state;
  owner_t     own;
  logic [2:0] r_off;
  logic [3:0] r_mask;

  logic              ls_bad;
  logic              if_bad;
  logic [7:0]        wstrb;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rdata_ext;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;
`endif

  // LS wins ties; readies are forced low while reset is held.
  assign ls_req_ready = ~rst & (state == IDLE) & ls_req_valid;
  assign if_req_ready = ~rst & (state == IDLE) & if_req_valid
                      & ~ls_req_valid;

  assign ls_bad = misaligned(ls_mask, ls_addr[2:0]);
  assign if_bad = |if_addr[1:0];

  ysyx_22040088_mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .w_mask    (ls_mask),
    .w_off     (ls_addr[2:0]),
    .wdata     (ls_wdata),
    .r_mask    (r_mask),
    .r_off     (r_off),
    .rdata     (mem_resp_data),
    .wstrb     (wstrb),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  // Transaction FSM with registered memory and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      own           <= OWN_IF;
      r_off         <= '0;
      r_mask        <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      if_resp_err   <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_resp_data  <= '0;
      ls_resp_err   <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      cnt           <= '0;
`endif
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ls_req_ready) begin
            own      <= OWN_LS;
            r_off    <= ls_addr[2:0];
            r_mask   <= ls_mask;
            mem_addr <= {ls_addr[ADDR_W-1:3], 3'b000};
            mem_wen  <= ls_wen;
            mem_wdata <= ls_wen ? wdata_sh : '0;
            mem_wstrb <= ls_wen ? wstrb : 8'h00;
            if (ls_bad) begin
              state         <= ERR;
              ls_resp_valid <= 1'b1;
              ls_resp_err   <= 1'b1;
              ls_resp_data  <= '0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end
          end else if (if_req_ready) begin
            own       <= OWN_IF;
            r_off     <= if_addr[2:0];
            r_mask    <= MASK_W;
            mem_addr  <= {if_addr[ADDR_W-1:3], 3'b000};
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= 8'h00;
            if (if_bad) begin
              state         <= ERR;
              if_resp_valid <= 1'b1;
              if_resp_err   <= 1'b1;
              if_resp_data  <= '0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
`ifdef MEMARB_TIMEOUT_EN
            cnt           <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state <= RESP;
            if (own == OWN_LS) begin
              ls_resp_valid <= 1'b1;
              ls_resp_err   <= 1'b0;
              ls_resp_data  <= rdata_ext;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_err   <= 1'b0;
              if_resp_data  <= r_off[2] ? mem_resp_data[63:32]
                                        : mem_resp_data[31:0];
            end
`ifdef MEMARB_TIMEOUT_EN
          end else if (cnt == TO_LAST) begin
            state <= DRAIN;
            if (own == OWN_LS) begin
              ls_resp_valid <= 1'b1;
              ls_resp_err   <= 1'b1;
              ls_resp_data  <= '0;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_err   <= 1'b1;
              if_resp_data  <= '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
`endif
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        // The late response of a timed-out access is swallowed here.
        DRAIN:   if (mem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_mem_arbiter.sv
// Randomised self-checking bench for ysyx_22040088_mem_arbiter.
// Covers the MEMARB_TIMEOUT_EN build when that macro is defined.
module tb_ysyx_22040088_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_addr;
  logic        if_resp_valid, if_resp_err;
  logic [31:0] if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_wen;
  logic [3:0]  ls_mask;
  logic [63:0] ls_addr, ls_wdata;
  logic        ls_resp_valid, ls_resp_err;
  logic [63:0] ls_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  int n_chk = 0;
  int n_err = 0;

  ysyx_22040088_mem_arbiter #(
    .ADDR_W (64),
    .DATA_W (64)
`ifdef MEMARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .if_resp_err    (if_resp_err),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_wen         (ls_wen),
    .ls_mask        (ls_mask),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_data   (ls_resp_data),
    .ls_resp_err    (ls_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes from the one-hot mask; 0 = illegal.
  function automatic int nbytes(input logic [3:0] m);
    if (m == 4'b0001) return 8;
    if (m == 4'b0010) return 4;
    if (m == 4'b0100) return 2;
    if (m == 4'b1000) return 1;
    return 0;
  endfunction

  function automatic logic [63:0] r64;
    return {$urandom, $urandom};
  endfunction

  // One complete request: drive, check handshake, play memory, check reply.
  task automatic xact(input bit is_ls, input bit wen,
                      input logic [3:0] mask, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [63:0] rd,
                      input int rdly, input int sdly);
    int          nb, off;
    bit          bad;
    logic [63:0] lm, exp_r, exp_w, exp_a;
    logic [7:0]  exp_s;
    logic        rv, re;
    logic [63:0] rdat;
    off   = int'(addr[2:0]);
    nb    = is_ls ? nbytes(mask) : 4;
    bad   = (nb == 0) || ((off % nb) != 0);
    lm    = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                      : ((64'd1 << (8 * nb)) - 64'd1);
    exp_a = addr & ~64'd7;
    exp_s = (is_ls && wen) ? 8'(((1 << nb) - 1) << off) : 8'h00;
    exp_w = wd << (8 * off);
    exp_r = (rd >> (8 * off)) & lm;
    if (is_ls) begin
      ls_req_valid = 1'b1;
      ls_wen = wen; ls_mask = mask;
      ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req_valid = 1'b1;
      if_addr = addr;
    end
    #1;
    if (is_ls) begin
      check("ls_ready", ls_req_ready, 1);
      if (if_req_valid) check("if_blocked", if_req_ready, 0);
    end else begin
      check("if_ready", if_req_ready, 1);
    end
    tick;
    if (is_ls) ls_req_valid = 1'b0;
    else       if_req_valid = 1'b0;
    if (!bad) begin
      for (int i = 0; i <= rdly; i++) begin
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_addr, exp_a);
        check("req_wen", mem_wen, is_ls && wen);
        check("req_wstrb", mem_wstrb, exp_s);
        if (is_ls && wen) check("req_wdata", mem_wdata, exp_w);
        if (i == rdly) mem_req_ready = 1'b1;
        tick;
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= sdly; i++) begin
        check("wait_req", mem_req_valid, 0);
        check("wait_rv", is_ls ? ls_resp_valid : if_resp_valid, 0);
        if (i == sdly) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rd;
        end
        tick;
      end
      mem_resp_valid = 1'b0;
      mem_resp_data  = r64();
    end else begin
      check("err_noreq", mem_req_valid, 0);
    end
    rv   = is_ls ? ls_resp_valid : if_resp_valid;
    re   = is_ls ? ls_resp_err : if_resp_err;
    rdat = is_ls ? ls_resp_data : {32'h0, if_resp_data};
    check("resp_valid", rv, 1);
    check("resp_err", re, bad);
    check("resp_data", rdat, bad ? 64'h0 : exp_r);
    if (if_req_valid) check("pulse_noacc", if_req_ready, 0);
    tick;
    check("resp_1cyc", is_ls ? ls_resp_valid : if_resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_wen = 0; ls_mask = 0;
    ls_addr = 0; ls_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (2) @(posedge clk);
    #1;
    ls_req_valid = 1'b1;
    #1;
    check("rst_ls_ready", ls_req_ready, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_ls_rv", ls_resp_valid, 0);
    check("rst_wstrb", mem_wstrb, 0);
    ls_req_valid = 1'b0;
    rst = 1'b0;
    tick;

    xact(1, 1, 4'b0010, 64'h8000_0006, 64'h1122_3344, 0, 0, 0);
    xact(1, 1, 4'b0010, 64'h8000_0004, 64'h1122_3344, 0, 0, 0);
    xact(1, 0, 4'b0000, 64'h8000_0000, 0, 0, 0, 0);
    xact(1, 0, 4'b0011, 64'h8000_0000, 0, 0, 0, 0);
    xact(0, 0, 4'b0010, 64'h8000_0002, 0, 0, 0, 0);

    if_req_valid = 1'b1;
    if_addr = 64'h8000_0004;
    xact(1, 0, 4'b1000, 64'h8000_0003, 0,
         64'h8877_6655_4433_2211, 0, 0);
    xact(0, 0, 4'b0010, 64'h8000_0004, 0,
         64'hDEAD_BEEF_0000_0013, 5, 0);

    ls_req_valid = 1'b1; ls_wen = 0; ls_mask = 4'b0001;
    ls_addr = 64'h8000_0010;
    tick;
    ls_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    ls_req_valid = 1'b1;
    if_req_valid = 1'b1;
    #1;
    check("arst_req_valid", mem_req_valid, 0);
    check("arst_ls_ready", ls_req_ready, 0);
    check("arst_if_ready", if_req_ready, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_ls_data", ls_resp_data, 0);
    ls_req_valid = 1'b0;
    if_req_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    mem_resp_valid = 1'b1;
    tick;
    mem_resp_valid = 1'b0;
    check("late_ls_rv", ls_resp_valid, 0);
    check("late_if_rv", if_resp_valid, 0);
    tick;
    check("late_ls_rv2", ls_resp_valid, 0);

`ifdef MEMARB_TIMEOUT_EN
    begin
      int seen;
      seen = -1;
      ls_req_valid = 1'b1; ls_wen = 0; ls_mask = 4'b0010;
      ls_addr = 64'h8000_0020;
      tick;
      ls_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      for (int i = 0; i < 100 && seen < 0; i++) begin
        if (ls_resp_valid) seen = i;
        else tick;
      end
      check("to_cycles", 64'(seen), 16);
      check("to_err", ls_resp_err, 1);
      check("to_data", ls_resp_data, 0);
      ls_req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick;
        check("drain_ready", ls_req_ready, 0);
        check("drain_req", mem_req_valid, 0);
      end
      mem_resp_valid = 1'b1;
      tick;
      mem_resp_valid = 1'b0;
      check("drain_exit", ls_req_ready, 1);
      check("drain_norv", ls_resp_valid, 0);
      ls_req_valid = 1'b0;
      tick;
    end
`endif

    for (int t = 0; t < 60; t++) begin
      bit          is_ls, wen;
      logic [3:0]  m;
      logic [63:0] a;
      int          r;
      is_ls = $urandom_range(0, 1) == 1;
      wen   = $urandom_range(0, 1) == 1;
      r     = $urandom_range(0, 9);
      m     = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom);
      a     = {32'h0, 32'h8000_0000 | ($urandom & 32'hFF)};
      if (!is_ls && $urandom_range(0, 9) < 8) a = a & ~64'd3;
      xact(is_ls, wen, m, a, r64(), r64(),
           $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        mem_resp_valid = 1'b1;
        tick;
        mem_resp_valid = 1'b0;
        check("stray_ls", ls_resp_valid, 0);
        check("stray_if", if_resp_valid, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_mem_arbiter.md
Name: ysyx_22040088_mem_arbiter

Overview:
- Sequences all memory traffic of the NPC core through one shared memory request/response port.
- Arbitrates between the instruction-fetch requester (IF) and the load/store requester (LS). The LS side is driven by the control unit's mem_ena/mem_wen/mem_mask.
- Performs byte-lane alignment: write strobes and shifted write data out, extracted read data back.
- Sits between IFU/LSU and the memory/bus bridge; one outstanding transaction at a time.

Parameters:
- ADDR_W, 64, address width of requesters and memory port
- DATA_W, 64, memory data width (fixed 8-byte lanes)
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit, used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  one-cycle pulse, fetch result
- if_resp_data  out  32  instruction word
- if_resp_err  out  1  fetch misaligned or timed out
- ls_req_valid  in  1  load/store request (control unit mem_ena)
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_wen  in  1  1 = store (mem_wen)
- ls_mask  in  4  size one-hot (mem_mask): 0001 dword, 0010 word, 0100 half, 1000 byte
- ls_addr  in  ADDR_W  byte address
- ls_wdata  in  DATA_W  store data, LSB-justified
- ls_resp_valid  out  1  one-cycle pulse, load/store done
- ls_resp_data  out  DATA_W  load data, zero-extended to DATA_W
- ls_resp_err  out  1  misaligned, illegal mask, or timeout
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  request address with bits [2:0] = 0
- mem_wen  out  1  write
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_wstrb  out  8  byte strobes; 0 for reads
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  aligned doubleword

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; latched request cleared; timeout counter 0.
- Reset mid-transaction abandons it. The memory side must tolerate a dropped response.
- States and transitions:
  - IDLE: accept one request; go to REQ. If the request is bad (see error rules), go to ERR instead.
  - REQ: mem_req_valid=1, all request fields stable until mem_req_ready=1; then go to WAIT.
  - WAIT: on mem_resp_valid, register the response and go to RESP.
  - RESP: pulse the owner's resp_valid for exactly 1 cycle; go to IDLE.
  - ERR: pulse the owner's resp_valid with err=1 and data=0 for 1 cycle; no memory transaction; go to IDLE.
- Arbitration (combinational, IDLE only):
  - ls_req_ready = IDLE & ls_req_valid.
  - if_req_ready = IDLE & if_req_valid & ~ls_req_valid.
  - LS has fixed priority, since the current instruction's data access precedes the next fetch.
- Minimum latency is accept → resp_valid in 3 cycles, with mem_req_ready and mem_resp_valid each asserted the first cycle they are allowed.
- A mem_resp_valid outside WAIT is ignored.
- Lanes: off = addr[2:0].
  - mem_wstrb = {FF, 0F, 03, 01}[size] << off.
  - mem_wdata = ls_wdata << (8*off).
  - Load: ls_resp_data = (mem_resp_data >> 8*off), masked to size, zero-extended. Sign extension is done by the core writeback.
  - Fetch: if_resp_data = addr[2] ? mem_resp_data[63:32] : mem_resp_data[31:0].
- Error rules:
  - LS: misaligned when dword has off≠0, word has off[1:0]≠0, or half has off[0]≠0. ls_mask not one-hot (including 0000) is also an error.
  - IF: if_addr[1:0]≠0 is an error.
  - An errored request still handshakes (ready=1 in IDLE), then goes through ERR.
- No new request is accepted in the same cycle a response is pulsed.

Optional Feature:
- Macro MEMARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter, reset on entry to WAIT, increments each WAIT cycle.
  - At TIMEOUT_CYCLES with no mem_resp_valid, the owner gets resp_valid with err=1 and data=0.
  - FSM then enters DRAIN: no requests accepted, mem_req_valid=0; leave to IDLE on the next mem_resp_valid, which is discarded.
- When undefined: no counter, no DRAIN state; WAIT holds indefinitely.

Decomposition:
- Package ysyx_22040088_mem_pkg:
  - state enum (IDLE, REQ, WAIT, RESP, ERR, DRAIN)
  - mask one-hot constants MASK_D/W/H/B
  - owner encoding (OWN_IF, OWN_LS)
  - function size_to_strb(mask)
  - function misaligned(mask, off)
- Sub-module ysyx_22040088_mem_lane_align: combinational wstrb/wdata generation and read-data extraction; instantiated once.

Test Plan:
- LS store word, addr=0x8000_0006 → ERR, ls_resp_err=1, no mem_req_valid. Same store at addr=0x8000_0004 with wdata=0x1122_3344 → mem_addr=0x8000_0000, mem_wstrb=0xF0, mem_wdata=0x1122_3344_0000_0000.
- Simultaneous if_req_valid and ls_req_valid in IDLE → ls_req_ready=1, if_req_ready=0. After the LS response, the IF request is granted.
- Byte load, addr=0x...3, mem_resp_data=0x8877_6655_4433_2211 → ls_resp_data=0x44, err=0, 3 cycles after accept.
- Fetch addr=0x8000_0004, mem_resp_data=0xDEAD_BEEF_0000_0013 → if_resp_data=0xDEADBEEF. mem_req_ready held low 5 cycles → request fields stable throughout.
- rst asserted while in WAIT → all outputs 0 immediately; late mem_resp_valid produces no resp pulse.
- With MEMARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no memory response → ls_resp_err pulse after 16 WAIT cycles. A new request is refused until a stale mem_resp_valid arrives.
